// File: rtl/hgcal_input_quant_packer.sv
// Quantises a stream of unsigned sensor samples to 2-bit codes and packs one frame
// of N_CH codes into a flat vector for the first LUT layer; flags short/long frames.
module hgcal_input_quant_packer #(
    parameter int unsigned N_CH  = 48,
    parameter int unsigned IN_W  = 8,
    parameter int unsigned T1    = 16,
    parameter int unsigned T2    = 64,
    parameter int unsigned T3    = 128,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_W-1:0]     s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*N_CH-1:0]   m_data,
    output logic                err_short,
    output logic                err_long,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned VEC_W = 2 * N_CH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    generate
        if (!((T1 < T2) && (T2 < T3) && (64'(T3) < (64'd1 << IN_W)))) begin : g_bad_thresholds
            $error("hgcal_input_quant_packer: thresholds must satisfy T1 < T2 < T3 < 2**IN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [VEC_W-1:0]  slots_nxt;
    logic [1:0]        code_c;
    logic              accept_c;
    logic              last_slot_c;
    logic              fill_acc_c;
    logic              deliver_c;

    assign accept_c    = s_valid && s_ready;
    assign last_slot_c = (idx == LAST_IDX);
    assign fill_acc_c  = (state == FILL) && accept_c;
    assign deliver_c   = (state == HOLD) && m_ready;

    // Three-threshold quantiser
    always_comb begin
        code_c = 2'd0;
        if (s_data >= IN_W'(T3)) begin
            code_c = 2'd3;
        end else if (s_data >= IN_W'(T2)) begin
            code_c = 2'd2;
        end else if (s_data >= IN_W'(T1)) begin
            code_c = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (accept_c) begin
                    if (s_last) begin
                        state_nxt = HOLD;
                    end else if (last_slot_c) begin
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (accept_c && s_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        s_ready = (state != HOLD);
        m_valid = (state == HOLD);
    end

    // Slot write; a short frame zeroes every slot above the final index
    always_comb begin
        slots_nxt = m_data;
        if (fill_acc_c) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (IDX_W'(k) == idx) begin
                    slots_nxt[2*k +: 2] = code_c;
                end else if (s_last && (IDX_W'(k) > idx)) begin
                    slots_nxt[2*k +: 2] = 2'b00;
                end
            end
        end else if (deliver_c) begin
            slots_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            m_data    <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            m_data    <= slots_nxt;
            err_short <= fill_acc_c && s_last && !last_slot_c;
            err_long  <= fill_acc_c && !s_last && last_slot_c;
            if (deliver_c) begin
                idx       <= '0;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end else if (fill_acc_c && !last_slot_c) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hgcal_input_quant_packer.sv
// Bench for hgcal_input_quant_packer (N_CH=4, CNT_W=2): directed frames from the test
// plan plus randomized frames checked against a frame-level reference model.
module tb_hgcal_input_quant_packer;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                s_valid;
    logic                s_ready;
    logic [7:0]          s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [2*N_CH-1:0]   m_data;
    logic                err_short;
    logic                err_long;
    logic [CNT_W-1:0]    frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    int short_cyc = 0;
    int long_cyc  = 0;
    int delivered = 0;

    logic [7:0]       fr [0:15];
    int               fr_len;
    logic [CNT_W-1:0] exp_cnt;

    hgcal_input_quant_packer #(
        .N_CH (N_CH),
        .IN_W (8),
        .T1   (16),
        .T2   (64),
        .T3   (128),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .err_short(err_short),
        .err_long (err_long),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Pulse-cycle and delivery counters, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_short) short_cyc++;
            if (err_long) long_cyc++;
            if (m_valid && m_ready) delivered++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] qcode(input logic [7:0] v);
        if (v >= 8'd128) return 2'd3;
        if (v >= 8'd64)  return 2'd2;
        if (v >= 8'd16)  return 2'd1;
        return 2'd0;
    endfunction

    // Expected vector: first min(len, N_CH) samples quantised into slots, rest zero
    function automatic logic [2*N_CH-1:0] model_vec();
        logic [2*N_CH-1:0] v;
        v = '0;
        for (int k = 0; k < fr_len && k < int'(N_CH); k++) v[2*k +: 2] = qcode(fr[k]);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [7:0] d, input logic last, input bit gaps);
        int w;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
                step();
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        w = 0;
        while (!s_ready && w < 20) begin
            step();
            w++;
        end
        check("s_ready_accept", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        fr[0] = a; fr[1] = b; fr[2] = c; fr[3] = d;
        fr_len = 4;
    endtask

    task automatic run_frame(input int hold, input bit gaps);
        logic [2*N_CH-1:0] expv;
        int s0, l0, d0;
        bit exp_short, exp_long;
        expv      = model_vec();
        exp_short = (fr_len < int'(N_CH));
        exp_long  = (fr_len > int'(N_CH));
        s0 = short_cyc; l0 = long_cyc; d0 = delivered;
        for (int i = 0; i < fr_len; i++) send_sample(fr[i], (i == fr_len - 1), gaps);
        check("m_valid_latency", 32'(m_valid), 32'd1);
        check("m_data", 32'(m_data), 32'(expv));
        check("s_ready_hold", 32'(s_ready), 32'd0);
        check("err_short_timing", 32'(err_short), 32'(exp_short));
        for (int c = 0; c < hold; c++) begin
            m_ready = 1'b0;
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = 1'b1;
            step();
            check("bp_m_valid", 32'(m_valid), 32'd1);
            check("bp_m_data", 32'(m_data), 32'(expv));
            check("bp_s_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("frame_cnt_pre", 32'(frame_cnt), 32'(exp_cnt));
        step();
        m_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        check("m_valid_post", 32'(m_valid), 32'd0);
        check("s_ready_post", 32'(s_ready), 32'd1);
        check("frame_cnt_post", 32'(frame_cnt), 32'(exp_cnt));
        check("err_short_cycles", 32'(short_cyc - s0), 32'(exp_short));
        check("err_long_cycles", 32'(long_cyc - l0), 32'(exp_long));
        check("delivered", 32'(delivered - d0), 32'd1);
    endtask

    task automatic random_frame();
        fr_len = $urandom_range(1, N_CH + 2);
        for (int i = 0; i < fr_len; i++) fr[i] = 8'($urandom);
        run_frame($urandom_range(0, 3), 1'b1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        exp_cnt = '0;
        fr_len  = 0;
        repeat (3) step();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_err_short", 32'(err_short), 32'd0);
        check("rst_err_long", 32'(err_long), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        step();

        // Codes and packing
        load4(8'h00, 8'h10, 8'h40, 8'hFF);
        run_frame(0, 1'b0);
        check("pack_dir", 32'(frame_cnt), 32'd1);

        // Threshold edges
        load4(8'd15, 8'd63, 8'd127, 8'd128);
        run_frame(0, 1'b0);
        // Threshold edges, second frame, with 5 cycles of backpressure
        load4(8'd16, 8'd64, 8'd0, 8'd255);
        run_frame(5, 1'b0);

        // Short frame
        fr[0] = 8'hFF; fr[1] = 8'hFF; fr_len = 2;
        run_frame(0, 1'b0);
        // Single-sample frame
        fr[0] = 8'h50; fr_len = 1;
        run_frame(1, 1'b0);
        // Long frame
        for (int i = 0; i < 6; i++) fr[i] = 8'h80;
        fr_len = 6;
        run_frame(0, 1'b0);

        for (int f = 0; f < 24; f++) random_frame();

        // Reset mid-frame discards the partial vector
        send_sample(8'hFF, 1'b0, 1'b0);
        send_sample(8'hFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data", 32'(m_data), 32'd0);
        check("midrst_err_short", 32'(err_short), 32'd0);
        check("midrst_err_long", 32'(err_long), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        step();
        rst_n   = 1'b1;
        exp_cnt = '0;
        #1;
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        step();
        load4(8'h00, 8'h20, 8'h90, 8'h41);
        run_frame(0, 1'b0);
        for (int f = 0; f < 4; f++) random_frame();
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
